// File: rtl/std_sram_singleport_reqctrl_pkg.sv
// Shared definitions for the single-port SRAM request controller.
// Holds the default read latency and a constant-foldable clog2 helper.
package std_sram_singleport_reqctrl_pkg;

  localparam int STD_SRAM_RD_LATENCY_DEFAULT = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/std_sram_rsp_fifo.sv
// Synchronous response FIFO with async-reset pointers and a count output.
// Pointers wrap at DEPTH; an assertion flags a push into a full FIFO without a pop.
module std_sram_rsp_fifo
  import std_sram_singleport_reqctrl_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= nxt(wr_q);
      if (pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == CNT_W'(DEPTH))
  );

endmodule

// File: rtl/std_sram_singleport_reqctrl.sv
// Credit-guarded single-port SRAM request controller with in-order read responses.
// Optional write acks: define STD_SRAM_SINGLEPORT_REQCTRL_WR_ACK_EN.
module std_sram_singleport_reqctrl
  import std_sram_singleport_reqctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RD_LATENCY = STD_SRAM_RD_LATENCY_DEFAULT,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  aregrst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_din,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
`ifdef STD_SRAM_SINGLEPORT_REQCTRL_WR_ACK_EN
  output logic                  rsp_is_wr,
`endif
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int CNT_W = clog2(RSP_DEPTH + RD_LATENCY + 1);
`ifdef STD_SRAM_SINGLEPORT_REQCTRL_WR_ACK_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]      fifo_cnt, inflight, credit;
  logic [FW-1:0]         push_data, pop_data;
  logic                  push, pop, empty;

  assign sram_en   = req_valid & req_ready;
  assign sram_we   = req_we;
  assign sram_addr = req_addr;
  assign sram_din  = req_din;

`ifdef STD_SRAM_SINGLEPORT_REQCTRL_WR_ACK_EN
  logic [RD_LATENCY-1:0] wr_q, wr_d;

  always_comb begin
    vld_d    = '0;
    wr_d     = '0;
    vld_d[0] = sram_en;
    wr_d[0]  = sram_en & sram_we;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      wr_d[i]  = wr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge aregrst) begin
    if (aregrst) wr_q <= '0;
    else         wr_q <= wr_d;
  end

  // Write acks carry zero data so consumers never see stale read bits.
  assign push_data = {wr_q[RD_LATENCY-1],
                      sram_dout & {DATA_WIDTH{~wr_q[RD_LATENCY-1]}}};
  assign rsp_is_wr = ~empty & pop_data[DATA_WIDTH];
`else
  always_comb begin
    vld_d    = '0;
    vld_d[0] = sram_en & ~sram_we;
    for (int i = 1; i < RD_LATENCY; i++) vld_d[i] = vld_q[i-1];
  end

  assign push_data = sram_dout;
`endif

  always_ff @(posedge clk or posedge aregrst) begin
    if (aregrst) vld_q <= '0;
    else         vld_q <= vld_d;
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + CNT_W'(vld_q[i]);
  end

  // Credits come from registered counts only; a pop frees space next cycle.
  assign credit    = fifo_cnt + inflight;
  assign req_ready = ~aregrst & (credit < CNT_W'(RSP_DEPTH));

  assign push      = vld_q[RD_LATENCY-1];
  assign rsp_valid = ~empty;
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = pop_data[DATA_WIDTH-1:0];

  std_sram_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (aregrst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (pop_data),
    .empty (empty),
    .count (fifo_cnt)
  );

endmodule
